hyp_share_sched: RTL
====================

# hyp_share_sched

Round-robin scheduler that shares one iterative hypotenuse engine between up to four requesters. The engine computes floor(sqrt(x² + y²)) for 8-bit x, y. It uses shift-add squaring and bit-serial square-root extraction over fixed multi-cycle phases, so there is no single-cycle multiplier on the squaring path. The block sits between the per-channel input ports and the result bus, and is the only owner of the engine.

## Interface

Parameters:
- NREQ, default 2: number of requesters, legal range 2..4.

Ports:
- clk, input, 1: single clock; all state changes on the rising edge.
- rst_n, input, 1: reset, synchronous and active-low.
- ena, input, 1: global enable; when low, all state freezes.
- req_valid, input, NREQ: per-requester job request.
- req_x, input, 8*NREQ: operand x; requester i occupies bits [8i+7:8i].
- req_y, input, 8*NREQ: operand y, packed the same way as req_x.
- req_ready, output, NREQ: one-hot acceptance strobe.
- rsp_valid, output, 1: one-cycle result strobe.
- rsp_id, output, 2: index of the requester that owns rsp_data.
- rsp_data, output, 9: floor(sqrt(x² + y²)), range 0..360.
- busy, output, 1: high whenever the state is not IDLE.

## Operation

- States: IDLE, SQX, SQY, ROOT, DONE.
- IDLE:
  - Winner selection is round-robin. Search starts at last_grant+1 (mod NREQ) and takes the first i with req_valid[i]=1.
  - req_ready[winner] is high combinationally in IDLE while ena=1; all other bits are 0.
  - A transfer occurs at an edge where req_valid[i] & req_ready[i]. On that edge: capture x and y, clear acc (17 bits), set rsp_id and last_grant to i, and go to SQX.
- SQX: 8 cycles, k = 0..7. If x[k]=1 then acc += x << k. Go to SQY after k=7.
- SQY: 8 cycles, same shift-add rule applied to y. After k=7, acc = x² + y², with a maximum of 130050 (17 bits, no truncation). Go to ROOT.
- ROOT: 9 cycles, b = 8 down to 0.
  - Trial value t = root | (1 << b), where root is 9 bits and cleared on entry.
  - If t*t ≤ acc, set root = t. The comparison is 18-bit, unsigned.
  - After b=0, load rsp_data = root and go to DONE.
- DONE: rsp_valid=1 for exactly one enabled cycle, then go to IDLE.
- rsp_data and rsp_id hold their values between results.
- req_ready is 0 in every state other than IDLE, so requests presented while busy wait. A requester may drop req_valid before it is granted; no job is created in that case.
- Operands are captured once at acceptance. Changes to req_x/req_y afterwards have no effect on the job in flight.
- ena=0:
  - State, counters, acc and root hold.
  - req_ready and rsp_valid are forced to 0.
  - A pending DONE emits its strobe on the first cycle after ena returns.
- Reset values:
  - state = IDLE, last_grant = NREQ-1 (requester 0 has first priority), acc = 0, root = 0.
  - Outputs: req_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_data = 0, busy = 0.
- Reset asserted mid-operation, in any state, discards the job. No rsp_valid is produced for it, and the next job behaves exactly as after power-on reset.

## Timing

- Acceptance edge E0 moves the state to SQX.
  - SQX runs E1..E8, SQY runs E9..E16, ROOT runs E17..E25.
  - The state is DONE in the cycle after E25, so rsp_valid is sampled high at E26.
- Fixed latency of 26 enabled cycles from acceptance to result, independent of operand values.
- The state is back in IDLE after E26, and the next acceptance can occur at E27. Peak throughput is one job per 27 cycles.
- Each cycle with ena=0 extends the latency by exactly one cycle.
- When several requesters are valid in the same IDLE cycle, exactly one is granted. With requesters continuously valid, grants rotate 0, 1, …, NREQ-1, 0.

## Test plan

- Single job: requester 0 sends (3, 4) → req_ready[0] pulses for one cycle; 26 cycles later rsp_valid=1, rsp_id=0, rsp_data=5; busy is high throughout.
- Extremes:
  - (255, 255) → 360.
  - (0, 0) → 0.
  - (255, 0) → 255.
  - (1, 1) → 1.
  - Latency is 26 cycles in every case.
- Arbitration, NREQ=2: both requesters hold valid from reset with (6, 8) and (5, 12) → results 10 (id 0), 13 (id 1), 10 (id 0), spaced 27 cycles apart.
- Reset during ROOT: assert rst_n=0 for one cycle → no rsp_valid appears and all outputs read 0. Then send (8, 15) → 17 after 26 cycles, with requester 0 granted first.
- Stall: drop ena for 5 cycles during SQY on job (20, 21) → rsp_data=29 after 31 cycles; rsp_valid never high while ena=0.
- Operand change: alter req_x the cycle after acceptance → the result reflects the captured operands only.

Source files
------------

// File: rtl/hyp_share_sched.sv
// Round-robin front end for one shared iterative hypotenuse engine.
// Each job computes floor(sqrt(x*x + y*y)) with a fixed latency of 26 enabled cycles.
module hyp_share_sched #(
    parameter int NREQ = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_x,
    input  logic [8*NREQ-1:0] req_y,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    output logic [1:0]        rsp_id,
    output logic [8:0]        rsp_data,
    output logic              busy
);
    typedef enum logic [2:0] {IDLE, SQX, SQY, ROOT, DONE} state_t;

    state_t      state_q;
    logic [1:0]  last_q;
    logic [7:0]  x_q, y_q;
    logic [16:0] acc_q;
    logic [8:0]  root_q;
    logic [3:0]  cnt_q;

    logic [1:0]  win;
    logic        win_vld;
    logic [2:0]  idx;
    logic [7:0]  sel_x, sel_y;
    logic [8:0]  trial, root_d;
    logic [17:0] trial_sq;

    // Search starts one past the last grant and wraps at NREQ.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        sel_x   = '0;
        sel_y   = '0;
        idx     = '0;
        for (int off = 1; off <= NREQ; off++) begin
            idx = {1'b0, last_q} + 3'(off);
            if (idx >= 3'(NREQ)) idx = idx - 3'(NREQ);
            for (int i = 0; i < NREQ; i++) begin
                if (!win_vld && req_valid[i] && idx == 3'(i)) begin
                    win_vld = 1'b1;
                    win     = 2'(i);
                    sel_x   = req_x[8*i +: 8];
                    sel_y   = req_y[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++)
            req_ready[i] = (state_q == IDLE) && ena && win_vld && (win == 2'(i));
    end

    assign rsp_valid = (state_q == DONE) && ena;
    assign busy      = (state_q != IDLE);

    assign trial    = root_q | (9'd1 << cnt_q);
    assign trial_sq = 18'(trial) * 18'(trial);
    assign root_d   = (trial_sq <= {1'b0, acc_q}) ? trial : root_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_q   <= 2'(NREQ-1);
            x_q      <= '0;
            y_q      <= '0;
            acc_q    <= '0;
            root_q   <= '0;
            cnt_q    <= '0;
            rsp_id   <= '0;
            rsp_data <= '0;
        end else if (ena) begin
            unique case (state_q)
                IDLE: if (win_vld) begin
                    x_q     <= sel_x;
                    y_q     <= sel_y;
                    acc_q   <= '0;
                    cnt_q   <= '0;
                    rsp_id  <= win;
                    last_q  <= win;
                    state_q <= SQX;
                end
                SQX: begin
                    if (x_q[cnt_q[2:0]]) acc_q <= acc_q + (17'(x_q) << cnt_q[2:0]);
                    cnt_q <= (cnt_q == 4'd7) ? 4'd0 : cnt_q + 4'd1;
                    if (cnt_q == 4'd7) state_q <= SQY;
                end
                SQY: begin
                    if (y_q[cnt_q[2:0]]) acc_q <= acc_q + (17'(y_q) << cnt_q[2:0]);
                    if (cnt_q == 4'd7) begin
                        cnt_q   <= 4'd8;
                        root_q  <= '0;
                        state_q <= ROOT;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                ROOT: begin
                    root_q <= root_d;
                    if (cnt_q == 4'd0) begin
                        rsp_data <= root_d;
                        state_q  <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
